// File: rtl/odata_pool_arb_pkg.sv
// Shared types and helpers for the pool read arbiter: tag sizing,
// round-robin search and one-hot to index conversion.
package odata_pool_arb_pkg;

  // Largest requester count supported; helpers work on vectors this wide.
  localparam int unsigned MAX_NUM = 16;

  // Widest tag the arbiter can carry; modules narrow it to TAG_W.
  typedef logic [3:0] tag_t;

  // Tag width for n requesters, never below one bit.
  function automatic int unsigned tag_w(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  // First set bit of vld at or after ptr, wrapping at num; returns one-hot.
  function automatic logic [MAX_NUM-1:0] rr_search(input logic [MAX_NUM-1:0] vld,
                                                   input int unsigned ptr,
                                                   input int unsigned num);
    logic [MAX_NUM-1:0] gnt;
    logic               found;
    int unsigned        j;
    gnt   = '0;
    found = 1'b0;
    j     = 0;
    for (int unsigned i = 0; i < MAX_NUM; i++) begin
      if (i < num) begin
        j = ptr + i;
        if (j >= num) j = j - num;
        if (!found && vld[j[3:0]]) begin
          gnt[j[3:0]] = 1'b1;
          found       = 1'b1;
        end
      end
    end
    return gnt;
  endfunction

  // Index of the set bit of a one-hot vector (zero when none is set).
  function automatic tag_t onehot_to_index(input logic [MAX_NUM-1:0] oh);
    tag_t idx;
    idx = '0;
    for (int i = 0; i < MAX_NUM; i++)
      if (oh[i]) idx = idx | tag_t'(i);
    return idx;
  endfunction

endpackage

// File: rtl/odata_pool_tag_fifo.sv
// Synchronous FIFO holding the requester tag of every issued command
// until the matching burst's last beat is consumed.
module odata_pool_tag_fifo #(
  parameter  int DEPTH = 8,
  parameter  int WIDTH = 2,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             empty,
  output logic [AW:0]      count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  assign pop_data = mem[rd_ptr];
  assign empty    = (count == '0);

  // Tag storage; no reset needed, occupancy is tracked by count.
  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clock) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/odata_pool_rd_arbiter.sv
// Shares one in-order pool read engine among NUM requesters: round-robin
// command issue with requester tags, data bursts steered back by tag.
module odata_pool_rd_arbiter
  import odata_pool_arb_pkg::*;
#(
  parameter  int NUM     = 4,
  parameter  int ASIZE   = 32,
  parameter  int SSIZE   = 32,
  parameter  int DSIZE   = 32,
  parameter  int MAX_OUT = 8,
  localparam int TAG_W   = tag_w(NUM),
  localparam int CNT_W   = $clog2(MAX_OUT) + 1
) (
  input  logic                   clock,
  input  logic                   rst,
  input  logic [NUM-1:0]         req_valid,
  output logic [NUM-1:0]         req_ready,
  input  logic [NUM*ASIZE-1:0]   req_addr,
  input  logic [NUM*SSIZE-1:0]   req_size,
  output logic                   cmd_valid,
  input  logic                   cmd_ready,
  output logic [ASIZE+SSIZE-1:0] cmd_data,
  output logic [TAG_W-1:0]       cmd_tag,
  input  logic [DSIZE-1:0]       pool_tdata,
  input  logic                   pool_tlast,
  input  logic                   pool_tvalid,
  output logic                   pool_tready,
  output logic [DSIZE-1:0]       rsp_tdata,
  output logic                   rsp_tlast,
  output logic [NUM-1:0]         rsp_tvalid,
  input  logic [NUM-1:0]         rsp_tready,
  output logic [CNT_W-1:0]       outstanding,
  output logic                   orphan_err
);

  logic [TAG_W-1:0]   rr_ptr;
  logic [CNT_W-1:0]   fifo_count;
  logic               fifo_empty;
  logic [TAG_W-1:0]   head_tag;
  logic               push, pop;
  logic               load_en, load;
  logic [MAX_NUM-1:0] gnt_oh;
  logic [TAG_W-1:0]   win_idx;
  logic [ASIZE-1:0]   win_addr;
  logic [SSIZE-1:0]   win_size;

  // The slot's pending command counts against the credit limit too, so the
  // FIFO can never be pushed past MAX_OUT once that command is accepted.
  assign load_en = !rst && (!cmd_valid || cmd_ready) &&
                   ((32'(fifo_count) + 32'(cmd_valid)) < 32'(MAX_OUT));

  assign push = cmd_valid && cmd_ready;
  assign pop  = pool_tvalid && pool_tready && pool_tlast && !fifo_empty;

  // Round-robin grant and winner payload mux.
  always_comb begin
    gnt_oh = '0;
    if (load_en) gnt_oh = rr_search(MAX_NUM'(req_valid), 32'(rr_ptr), NUM);
    req_ready = gnt_oh[NUM-1:0];
    load      = |req_ready;
    win_idx   = TAG_W'(onehot_to_index(gnt_oh));
    win_addr  = '0;
    win_size  = '0;
    for (int i = 0; i < NUM; i++) begin
      if (req_ready[i]) begin
        win_addr = req_addr[i*ASIZE +: ASIZE];
        win_size = req_size[i*SSIZE +: SSIZE];
      end
    end
  end

  // Registered command slot; contents hold while stalled by cmd_ready.
  always_ff @(posedge clock) begin
    if (rst) begin
      cmd_valid <= 1'b0;
      cmd_data  <= '0;
      cmd_tag   <= '0;
      rr_ptr    <= '0;
    end else if (load) begin
      cmd_valid <= 1'b1;
      cmd_data  <= {win_addr, win_size};
      cmd_tag   <= win_idx;
      rr_ptr    <= (32'(win_idx) == NUM - 1) ? '0 : win_idx + 1'b1;
    end else if (cmd_ready) begin
      cmd_valid <= 1'b0;
    end
  end

  odata_pool_tag_fifo #(
    .DEPTH (MAX_OUT),
    .WIDTH (TAG_W)
  ) u_tag_fifo (
    .clock     (clock),
    .rst       (rst),
    .push      (push),
    .push_data (cmd_tag),
    .pop       (pop),
    .pop_data  (head_tag),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign outstanding = fifo_count;
  assign rsp_tdata   = pool_tdata;
  assign rsp_tlast   = pool_tlast;

  // Steer the stream to the head tag's owner; with no owner, sink and drop.
  always_comb begin
    rsp_tvalid  = '0;
    pool_tready = 1'b1;
    if (!fifo_empty) begin
      rsp_tvalid[head_tag] = pool_tvalid;
      pool_tready          = rsp_tready[head_tag];
    end
  end

  // Sticky flag for data that arrived with nothing outstanding.
  always_ff @(posedge clock) begin
    if (rst)                          orphan_err <= 1'b0;
    else if (fifo_empty && pool_tvalid) orphan_err <= 1'b1;
  end

endmodule

// File: tb/tb_odata_pool_rd_arbiter.sv
// Scoreboard bench for odata_pool_rd_arbiter: expected commands are queued
// at grant time and checked at cmd handshake; expected owners are queued at
// handshake and checked against the response steering.
module tb_odata_pool_rd_arbiter;
  localparam int NUM = 4, ASIZE = 32, SSIZE = 32, DSIZE = 32, MAX_OUT = 8;

  logic                   clock, rst;
  logic [NUM-1:0]         req_valid, req_ready;
  logic [NUM*ASIZE-1:0]   req_addr;
  logic [NUM*SSIZE-1:0]   req_size;
  logic                   cmd_valid, cmd_ready;
  logic [ASIZE+SSIZE-1:0] cmd_data;
  logic [1:0]             cmd_tag;
  logic [DSIZE-1:0]       pool_tdata, rsp_tdata;
  logic                   pool_tlast, pool_tvalid, pool_tready, rsp_tlast;
  logic [NUM-1:0]         rsp_tvalid, rsp_tready;
  logic [3:0]             outstanding;
  logic                   orphan_err;

  odata_pool_rd_arbiter #(.NUM(NUM), .ASIZE(ASIZE), .SSIZE(SSIZE), .DSIZE(DSIZE),
                          .MAX_OUT(MAX_OUT)) dut (
    .clock(clock), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_size(req_size), .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready), .cmd_data(cmd_data), .cmd_tag(cmd_tag),
    .pool_tdata(pool_tdata), .pool_tlast(pool_tlast), .pool_tvalid(pool_tvalid),
    .pool_tready(pool_tready), .rsp_tdata(rsp_tdata), .rsp_tlast(rsp_tlast),
    .rsp_tvalid(rsp_tvalid), .rsp_tready(rsp_tready), .outstanding(outstanding),
    .orphan_err(orphan_err));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct { int tag; logic [31:0] addr; logic [31:0] size; } cmd_t;
  cmd_t exp_cmd[$];
  int   own_q[$];
  int   m_rr;
  bit   m_cmd_valid, m_orphan;
  int   checks, errors;

  // One clock of the reference model: compare at negedge, advance, return at posedge+1.
  task automatic clk_cycle();
    cmd_t       e;
    logic [3:0] exp_v, exp_gnt;
    logic       exp_pr;
    int         pre_cnt, w;
    bit         do_pop, do_push, load_ok;
    @(negedge clock);
    pre_cnt = own_q.size();
    do_pop  = 0;
    do_push = 0;
    checks++;
    if (outstanding !== 4'(pre_cnt)) begin
      errors++; $display("FAIL outstanding: got %0d want %0d", outstanding, pre_cnt);
    end
    checks++;
    if (cmd_valid !== m_cmd_valid) begin
      errors++; $display("FAIL cmd_valid: got %b want %b", cmd_valid, m_cmd_valid);
    end
    checks++;
    if (orphan_err !== m_orphan) begin
      errors++; $display("FAIL orphan_err: got %b want %b", orphan_err, m_orphan);
    end
    if (m_cmd_valid && cmd_ready) begin
      checks++;
      if (exp_cmd.size() == 0) begin
        errors++; $display("FAIL cmd_unexpected: tag %0d with empty scoreboard", cmd_tag);
      end else begin
        e = exp_cmd.pop_front();
        do_push = 1;
        if (cmd_tag !== 2'(e.tag) || cmd_data !== {e.addr, e.size}) begin
          errors++;
          $display("FAIL cmd_issue: got tag %0d data %h want tag %0d data %h",
                   cmd_tag, cmd_data, e.tag, {e.addr, e.size});
        end
      end
    end
    if (pool_tvalid) begin
      if (pre_cnt == 0) begin
        exp_v = 4'b0; exp_pr = 1'b1; m_orphan = 1;
      end else begin
        exp_v = 4'(1 << own_q[0]); exp_pr = rsp_tready[own_q[0]];
        do_pop = exp_pr && pool_tlast;
      end
      checks++;
      if (rsp_tvalid !== exp_v || pool_tready !== exp_pr) begin
        errors++;
        $display("FAIL steer: got rsp_tvalid %b pool_tready %b want %b %b",
                 rsp_tvalid, pool_tready, exp_v, exp_pr);
      end
    end
    load_ok = (!m_cmd_valid || cmd_ready) && (pre_cnt + int'(m_cmd_valid) < MAX_OUT);
    exp_gnt = '0;
    w = -1;
    if (load_ok) begin
      for (int k = 0; k < NUM; k++) begin
        if (w < 0 && req_valid[(m_rr + k) % NUM]) w = (m_rr + k) % NUM;
      end
      if (w >= 0) exp_gnt = 4'(1 << w);
    end
    checks++;
    if (req_ready !== exp_gnt) begin
      errors++; $display("FAIL grant: got req_ready %b want %b", req_ready, exp_gnt);
    end
    if (do_pop) void'(own_q.pop_front());
    if (do_push) own_q.push_back(e.tag);
    if (w >= 0) begin
      exp_cmd.push_back('{w, req_addr[w*32 +: 32], req_size[w*32 +: 32]});
      m_rr = (w + 1) % NUM;
      m_cmd_valid = 1;
    end else if (cmd_ready) begin
      m_cmd_valid = 0;
    end
    @(posedge clock); #1;
  endtask

  task automatic do_reset();
    rst = 1; req_valid = '0; pool_tvalid = 0; pool_tlast = 0; cmd_ready = 0;
    @(posedge clock); #1;
    @(posedge clock); #1;
    rst = 0;
    exp_cmd.delete(); own_q.delete();
    m_rr = 0; m_cmd_valid = 0; m_orphan = 0;
  endtask

  // Flush the slot, then return one single-beat burst per outstanding tag.
  task automatic drain();
    int n;
    req_valid = '0; cmd_ready = 1; rsp_tready = '1; n = 0;
    while (m_cmd_valid && n < 20) begin clk_cycle(); n++; end
    pool_tvalid = 1; pool_tlast = 1;
    while (own_q.size() > 0 && n < 60) begin pool_tdata = 32'(n); clk_cycle(); n++; end
    pool_tvalid = 0; pool_tlast = 0;
    checks++;
    if (own_q.size() != 0 || m_cmd_valid) begin
      errors++; $display("FAIL drain_timeout: %0d tags left, want 0", own_q.size());
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (outstanding !== 4'd0) begin errors++; $display("FAIL rst_outstanding: got %0d want 0", outstanding); end
    checks++; if (cmd_valid !== 1'b0) begin errors++; $display("FAIL rst_cmd_valid: got %b want 0", cmd_valid); end
    checks++; if (req_ready !== 4'b0) begin errors++; $display("FAIL rst_req_ready: got %b want 0", req_ready); end
    checks++; if (rsp_tvalid !== 4'b0) begin errors++; $display("FAIL rst_rsp_tvalid: got %b want 0", rsp_tvalid); end
    checks++; if (orphan_err !== 1'b0) begin errors++; $display("FAIL rst_orphan: got %b want 0", orphan_err); end
  endtask

  task automatic test_single();
    cmd_ready = 1; req_valid = 4'b0100;
    clk_cycle();
    req_valid = '0;
    checks++;
    if (cmd_valid !== 1'b1 || cmd_tag !== 2'd2) begin
      errors++; $display("FAIL single_cmd: got valid %b tag %0d want 1 2", cmd_valid, cmd_tag);
    end
    clk_cycle();
    checks++; if (outstanding !== 4'd1) begin errors++; $display("FAIL single_out1: got %0d want 1", outstanding); end
    rsp_tready = 4'b0100; pool_tvalid = 1;
    for (int b = 0; b < 4; b++) begin
      pool_tdata = 32'hC000 + 32'(b); pool_tlast = (b == 3);
      #1;
      checks++;
      if (rsp_tvalid !== 4'b0100 || rsp_tdata !== 32'hC000 + 32'(b)) begin
        errors++; $display("FAIL single_beat%0d: got %b %h want 0100 %h", b, rsp_tvalid, rsp_tdata, 32'hC000 + 32'(b));
      end
      clk_cycle();
    end
    pool_tvalid = 0; pool_tlast = 0;
    checks++; if (outstanding !== 4'd0) begin errors++; $display("FAIL single_out0: got %0d want 0", outstanding); end
  endtask

  task automatic test_round_robin();
    logic [3:0] eg;
    do_reset();
    cmd_ready = 1; req_valid = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      #1;
      eg = 4'(1 << (k % 4));
      checks++;
      if (req_ready !== eg) begin errors++; $display("FAIL rr_grant%0d: got %b want %b", k, req_ready, eg); end
      clk_cycle();
      checks++;
      if (cmd_tag !== 2'(k % 4)) begin errors++; $display("FAIL rr_tag%0d: got %0d want %0d", k, cmd_tag, k % 4); end
    end
    drain();
  endtask

  task automatic test_full();
    do_reset();
    cmd_ready = 1; req_valid = 4'b0001;
    repeat (12) clk_cycle();
    #1;
    checks++; if (outstanding !== 4'd8) begin errors++; $display("FAIL full_out: got %0d want 8", outstanding); end
    checks++; if (req_ready !== 4'b0) begin errors++; $display("FAIL full_ready: got %b want 0", req_ready); end
    cmd_ready = 0; rsp_tready = '1; pool_tvalid = 1; pool_tlast = 1;
    clk_cycle();
    pool_tvalid = 0;
    clk_cycle();
    req_valid = '0;
    checks++;
    if (outstanding !== 4'd7 || cmd_valid !== 1'b1) begin
      errors++; $display("FAIL full_refill: got out %0d valid %b want 7 1", outstanding, cmd_valid);
    end
    cmd_ready = 1; pool_tvalid = 1;
    clk_cycle();
    pool_tvalid = 0;
    checks++; if (outstanding !== 4'd7) begin errors++; $display("FAIL push_pop: got %0d want 7", outstanding); end
    drain();
  endtask

  task automatic test_stall();
    do_reset();
    cmd_ready = 1; req_valid = 4'b0010;
    clk_cycle();
    req_valid = '0;
    clk_cycle();
    pool_tvalid = 1; pool_tlast = 1; pool_tdata = 32'hDEAD_BEEF; rsp_tready = 4'b1101;
    repeat (3) begin
      #1;
      checks++;
      if (pool_tready !== 1'b0 || rsp_tvalid !== 4'b0010 || rsp_tdata !== 32'hDEAD_BEEF) begin
        errors++; $display("FAIL stall: got ready %b tvalid %b data %h want 0 0010 deadbeef", pool_tready, rsp_tvalid, rsp_tdata);
      end
      clk_cycle();
    end
    rsp_tready = 4'b0010;
    #1;
    checks++; if (pool_tready !== 1'b1) begin errors++; $display("FAIL stall_release: got %b want 1", pool_tready); end
    clk_cycle();
    pool_tvalid = 0; pool_tlast = 0;
    checks++; if (outstanding !== 4'd0) begin errors++; $display("FAIL stall_out: got %0d want 0", outstanding); end
  endtask

  task automatic test_orphan();
    do_reset();
    rsp_tready = '0; pool_tvalid = 1; pool_tlast = 0; pool_tdata = 32'h55;
    #1;
    checks++;
    if (pool_tready !== 1'b1 || rsp_tvalid !== 4'b0) begin
      errors++; $display("FAIL orphan_sink: got ready %b tvalid %b want 1 0000", pool_tready, rsp_tvalid);
    end
    clk_cycle();
    pool_tvalid = 0;
    repeat (3) clk_cycle();
    checks++; if (orphan_err !== 1'b1) begin errors++; $display("FAIL orphan_sticky: got %b want 1", orphan_err); end
    do_reset();
    checks++; if (orphan_err !== 1'b0) begin errors++; $display("FAIL orphan_clear: got %b want 0", orphan_err); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    cmd_ready = 1; req_valid = 4'b0010;
    repeat (3) clk_cycle();
    req_valid = '0;
    clk_cycle();
    checks++; if (outstanding !== 4'd3) begin errors++; $display("FAIL mid_out3: got %0d want 3", outstanding); end
    rsp_tready = '1; pool_tvalid = 1; pool_tlast = 0;
    clk_cycle();
    do_reset();
    checks++;
    if (outstanding !== 4'd0 || cmd_valid !== 1'b0) begin
      errors++; $display("FAIL mid_rst: got out %0d valid %b want 0 0", outstanding, cmd_valid);
    end
    cmd_ready = 1; req_valid = 4'b1001;
    #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL mid_rr: got %b want 0001", req_ready); end
    clk_cycle();
    drain();
  endtask

  initial begin
    rst = 1; req_valid = '0; cmd_ready = 0; pool_tvalid = 0; pool_tlast = 0;
    pool_tdata = '0; rsp_tready = '0; checks = 0; errors = 0;
    for (int i = 0; i < NUM; i++) req_addr[i*32 +: 32] = 32'hA000_0000 + 32'(i * 16);
    req_size = {32'd16, 32'd4, 32'd8, 32'd0};
    test_reset();
    test_single();
    test_round_robin();
    test_full();
    test_stall();
    test_orphan();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, want finish before 200000");
    $fatal(1, "watchdog");
  end

endmodule
